// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: requester IDs and the
// request bundle that is muxed onto the single memory port.
package dmem_arb_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_DBG  = 1'b1
  } req_id_t;

  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, registered pointer to
// the requester granted most recently. Bit 0 is the core, bit 1 is debug.
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_id_t last_gnt;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_gnt == REQ_CORE) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= REQ_DBG;
    end else if (gnt[1]) begin
      last_gnt <= REQ_DBG;
    end else if (gnt[0]) begin
      last_gnt <= REQ_CORE;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the core load/store path and the
// debug/loader port; read data is registered back to the issuing side.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0] gnt;
  mem_req_t   core_rq;
  mem_req_t   dbg_rq;
  mem_req_t   sel_rq;
  logic       core_rd_p0;
  logic       dbg_rd_p0;
  logic       core_vld_p1;
  logic       dbg_vld_p1;
  logic [DATA_W-1:0] core_rdata_p1;
  logic [DATA_W-1:0] dbg_rdata_p1;

  rr_arbiter2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({dbg_req, core_req}),
    .gnt (gnt)
  );

  assign core_rq = '{we: core_we, addr: MEM_ADDR_W'(core_addr), wdata: MEM_DATA_W'(core_wdata)};
  assign dbg_rq  = '{we: dbg_we,  addr: MEM_ADDR_W'(dbg_addr),  wdata: MEM_DATA_W'(dbg_wdata)};

  assign core_gnt   = gnt[0];
  assign dbg_gnt    = gnt[1];
  assign core_stall = core_req & ~gnt[0];

  // Idle cycles present the core's address/data so the port never floats.
  assign sel_rq    = gnt[1] ? dbg_rq : core_rq;
  assign mem_wr_en = (|gnt) & sel_rq.we;
  assign mem_rd_en = (|gnt) & ~sel_rq.we;
  assign mem_addr  = ADDR_W'(sel_rq.addr);
  assign mem_wdata = DATA_W'(sel_rq.wdata);

  assign core_rd_p0 = gnt[0] & ~core_we;
  assign dbg_rd_p0  = gnt[1] & ~dbg_we;

  // ---- stage p0 -> p1: capture read data for the side that issued the read
  always_ff @(posedge clk) begin
    if (rst) begin
      core_vld_p1   <= 1'b0;
      dbg_vld_p1    <= 1'b0;
      core_rdata_p1 <= '0;
      dbg_rdata_p1  <= '0;
    end else begin
      core_vld_p1 <= core_rd_p0;
      dbg_vld_p1  <= dbg_rd_p0;
      if (core_rd_p0) core_rdata_p1 <= mem_rdata;
      if (dbg_rd_p0)  dbg_rdata_p1  <= mem_rdata;
    end
  end

  assign core_rvalid = core_vld_p1;
  assign core_rdata  = core_rdata_p1;
  assign dbg_rvalid  = dbg_vld_p1;
  assign dbg_rdata   = dbg_rdata_p1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Table-driven bench for dmem_arbiter with a behavioural memory and a
// scoreboard for the registered read-return path.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we, dbg_req, dbg_we;
  logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata;
  logic        core_gnt, core_stall, core_rvalid, dbg_gnt, dbg_rvalid;
  logic [31:0] core_rdata, dbg_rdata;
  logic        mem_rd_en, mem_wr_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Memory: combinational read, write commits at the grant edge.
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr[9:2]] <= mem_wdata;
  end

  typedef struct packed {
    logic rst;
    logic cr; logic cw; logic [31:0] ca; logic [31:0] cd;
    logic dr; logic dw; logic [31:0] da; logic [31:0] dd;
    logic gc; logic gd; logic wr; logic rd;
    logic [31:0] ea; logic [31:0] ewd;
  } vec_t;

  typedef struct packed {
    logic cv; logic [31:0] crd;
    logic dv; logic [31:0] drd;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  logic [31:0] exp_crd = 32'h0;
  logic [31:0] exp_drd = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input int r, input int cr, input int cw, input int ca, input int cd,
                     input int dr, input int dw, input int da, input int dd,
                     input int gc, input int gd, input int wr, input int rd,
                     input int ea, input int ewd);
    vec_t v;
    v.rst = 1'(r);
    v.cr = 1'(cr); v.cw = 1'(cw); v.ca = ca; v.cd = cd;
    v.dr = 1'(dr); v.dw = 1'(dw); v.da = da; v.dd = dd;
    v.gc = 1'(gc); v.gd = 1'(gd); v.wr = 1'(wr); v.rd = 1'(rd);
    v.ea = ea; v.ewd = ewd;
    vt.push_back(v);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("core_rvalid", {31'b0, core_rvalid}, {31'b0, e.cv});
      chk("core_rdata",  core_rdata, e.crd);
      chk("dbg_rvalid",  {31'b0, dbg_rvalid}, {31'b0, e.dv});
      chk("dbg_rdata",   dbg_rdata, e.drd);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int   waited;
    logic got;

    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'hA500_0000 | i;
      ref_mem[i] = 32'hA500_0000 | i;
    end
    mem[4]     = 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;

    rst = 1'b1;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    dbg_req  = 1'b0; dbg_we  = 1'b0; dbg_addr  = '0; dbg_wdata  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_core_rvalid", {31'b0, core_rvalid}, 32'h0);
    chk("rst_dbg_rvalid",  {31'b0, dbg_rvalid}, 32'h0);
    chk("rst_core_rdata",  core_rdata, 32'h0);
    chk("rst_dbg_rdata",   dbg_rdata, 32'h0);

    //  rst cr cw ca     cd      dr dw da     dd        gc gd wr rd ea     ewd
    add(1,  0, 0, 0,     0,      0, 0, 0,     0,        0, 0, 0, 0, 0,     0);
    add(0,  1, 0, 'h0,   0,      1, 1, 'h4,   'h55,     1, 0, 0, 1, 'h0,   0);
    add(0,  0, 0, 0,     0,      1, 1, 'h4,   'h55,     0, 1, 1, 0, 'h4,   'h55);
    add(0,  1, 0, 'h10,  0,      0, 0, 0,     0,        1, 0, 0, 1, 'h10,  0);
    add(0,  0, 0, 0,     0,      1, 1, 'h8,   'h1234,   0, 1, 1, 0, 'h8,   'h1234);
    add(0,  1, 0, 'h8,   0,      0, 0, 0,     0,        1, 0, 0, 1, 'h8,   0);
    add(0,  0, 0, 0,     0,      1, 0, 'h10,  0,        0, 1, 0, 1, 'h10,  0);
    for (int k = 0; k < 3; k++) begin
      add(0, 1, 0, 'h4,  0,      1, 0, 'h20,  0,        1, 0, 0, 1, 'h4,   0);
      add(0, 1, 0, 'h4,  0,      1, 0, 'h20,  0,        0, 1, 0, 1, 'h20,  0);
    end
    add(0,  0, 0, 'h30,  'h5,    0, 0, 'h40,  0,        0, 0, 0, 0, 'h30,  'h5);
    add(0,  1, 1, 'hC,   'h77,   0, 0, 0,     0,        1, 0, 1, 0, 'hC,   'h77);
    add(1,  1, 0, 'h10,  0,      0, 0, 0,     0,        1, 0, 0, 1, 'h10,  0);
    add(0,  1, 0, 'h0,   0,      1, 1, 'h1C,  'hBAD,    1, 0, 0, 1, 'h0,   0);
    add(0,  1, 0, 'h4,   0,      0, 0, 0,     0,        1, 0, 0, 1, 'h4,   0);
    add(0,  1, 0, 'h1C,  0,      0, 0, 0,     0,        1, 0, 0, 1, 'h1C,  0);
    add(0,  0, 0, 0,     0,      0, 0, 0,     0,        0, 0, 0, 0, 'h0,   0);

    for (int i = 0; i < vt.size(); i++) begin
      @(posedge clk);
      #1;
      pop_check();
      rst = vt[i].rst;
      core_req = vt[i].cr; core_we = vt[i].cw; core_addr = vt[i].ca; core_wdata = vt[i].cd;
      dbg_req  = vt[i].dr; dbg_we  = vt[i].dw; dbg_addr  = vt[i].da; dbg_wdata  = vt[i].dd;
      @(negedge clk);
      chk($sformatf("v%0d core_gnt", i),   {31'b0, core_gnt},   {31'b0, vt[i].gc});
      chk($sformatf("v%0d dbg_gnt", i),    {31'b0, dbg_gnt},    {31'b0, vt[i].gd});
      chk($sformatf("v%0d core_stall", i), {31'b0, core_stall}, {31'b0, vt[i].cr & ~vt[i].gc});
      chk($sformatf("v%0d mem_wr_en", i),  {31'b0, mem_wr_en},  {31'b0, vt[i].wr});
      chk($sformatf("v%0d mem_rd_en", i),  {31'b0, mem_rd_en},  {31'b0, vt[i].rd});
      chk($sformatf("v%0d mem_addr", i),   mem_addr,  vt[i].ea);
      chk($sformatf("v%0d mem_wdata", i),  mem_wdata, vt[i].ewd);

      e.cv = vt[i].gc & ~vt[i].cw & ~vt[i].rst;
      e.dv = vt[i].gd & ~vt[i].dw & ~vt[i].rst;
      if (vt[i].rst) begin
        exp_crd = 32'h0;
        exp_drd = 32'h0;
      end else begin
        if (e.cv) exp_crd = ref_mem[vt[i].ca[9:2]];
        if (e.dv) exp_drd = ref_mem[vt[i].da[9:2]];
      end
      e.crd = exp_crd;
      e.drd = exp_drd;
      sb.push_back(e);
      if (vt[i].gc && vt[i].cw) ref_mem[vt[i].ca[9:2]] = vt[i].cd;
      if (vt[i].gd && vt[i].dw) ref_mem[vt[i].da[9:2]] = vt[i].dd;
    end
    @(posedge clk);
    #1;
    pop_check();
    chk("sb_drained", sb.size(), 32'h0);
    chk("withdrawn_write_absent", mem[7], 32'hA500_0007);
    chk("dbg_write_0x4", mem[1], 32'h0000_0055);
    chk("core_write_0xC", mem[3], 32'h0000_0077);

    // Tie with core last served: debug wins first, core must follow within one cycle.
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h28; core_wdata = 32'h11;
    dbg_req  = 1'b1; dbg_we  = 1'b1; dbg_addr  = 32'h24; dbg_wdata  = 32'hCAFE;
    @(negedge clk);
    chk("tie_dbg_gnt", {31'b0, dbg_gnt}, 32'h1);
    chk("tie_core_stall", {31'b0, core_stall}, 32'h1);
    waited = 0;
    got = 1'b0;
    while (!got && waited < 4) begin
      @(posedge clk);
      #1;
      dbg_req = 1'b0;
      waited++;
      @(negedge clk);
      if (core_gnt) got = 1'b1;
    end
    chk("core_wait_cycles", waited, 32'h1);
    @(posedge clk);
    #1;
    core_req = 1'b0;
    @(negedge clk);
    chk("idle_wr_en", {31'b0, mem_wr_en}, 32'h0);
    chk("no_rvalid_after_writes", {30'b0, core_rvalid, dbg_rvalid}, 32'h0);
    chk("dbg_write_0x24", mem[9], 32'h0000_CAFE);
    chk("core_write_0x28", mem[10], 32'h0000_0011);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
